// File: rtl/decode_exec_pipe.sv
// Two-stage decode/execute pipeline for R-type ALU ops with an internal register file.
// Operands are read and the destination is written on the D->E edge, so dependent back-to-back ops need no bypass.
module decode_exec_pipe #(
    parameter int N        = 32,
    parameter int NREGS    = 32,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_instr,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [N-1:0]             out_result,
    output logic [4:0]               out_rd,
    output logic                     out_illegal,
    input  logic [$clog2(NREGS)-1:0] dbg_addr,
    output logic [N-1:0]             dbg_data
);
    localparam int AW = $clog2(NREGS);
    localparam int SW = $clog2(N);

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    logic                       d_valid_q, d_valid_d;
    logic [31:0]                d_instr_q;
    logic                       e_valid_q, e_valid_d;
    logic [N-1:0]               e_result_q;
    logic [4:0]                 e_rd_q;
    logic                       e_illegal_q;
    logic [NREGS-1:0][N-1:0]    rf_q;

    logic        d_load, e_load, rf_we;
    logic [6:0]  opc, f7;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    alu_op_e     op;
    logic        op_ok, in_range, legal;
    logic [N-1:0] a, b, alu_res, result_d;
    logic [SW-1:0] shamt;

    assign in_ready = !d_valid_q || !e_valid_q || out_ready;
    assign d_load   = in_valid && in_ready;
    assign e_load   = d_valid_q && (!e_valid_q || out_ready);

    assign opc = d_instr_q[6:0];
    assign rd  = d_instr_q[11:7];
    assign f3  = d_instr_q[14:12];
    assign rs2 = d_instr_q[19:15];
    assign rs1 = d_instr_q[24:20];
    assign f7  = d_instr_q[31:25];

    always_comb begin
        op    = ALU_ADD;
        op_ok = 1'b1;
        case ({f7, f3})
            {7'h00, 3'd0}: op = ALU_ADD;
            {7'h20, 3'd0}: op = ALU_SUB;
            {7'h00, 3'd1}: op = ALU_SLL;
            {7'h00, 3'd2}: op = ALU_SLT;
            {7'h00, 3'd3}: op = ALU_SLTU;
            {7'h00, 3'd4}: op = ALU_XOR;
            {7'h00, 3'd5}: op = ALU_SRL;
            {7'h20, 3'd5}: op = ALU_SRA;
            {7'h00, 3'd6}: op = ALU_OR;
            {7'h00, 3'd7}: op = ALU_AND;
            default:       op_ok = 1'b0;
        endcase
    end

    assign in_range = (32'(rd) < NREGS) && (32'(rs1) < NREGS) && (32'(rs2) < NREGS);
    assign legal    = (opc == 7'b0110011) && op_ok && in_range;

    // Out-of-range indices only alias here when the op is already flagged illegal.
    assign a = (ZERO_REG != 0 && rs1[AW-1:0] == '0) ? '0 : rf_q[rs1[AW-1:0]];
    assign b = (ZERO_REG != 0 && rs2[AW-1:0] == '0) ? '0 : rf_q[rs2[AW-1:0]];
    assign shamt = b[SW-1:0];

    always_comb begin
        alu_res = '0;
        case (op)
            ALU_ADD:  alu_res = a + b;
            ALU_SUB:  alu_res = a - b;
            ALU_SLL:  alu_res = a << shamt;
            ALU_SLT:  alu_res = {{(N-1){1'b0}}, $signed(a) < $signed(b)};
            ALU_SLTU: alu_res = {{(N-1){1'b0}}, a < b};
            ALU_XOR:  alu_res = a ^ b;
            ALU_SRL:  alu_res = a >> shamt;
            ALU_SRA:  alu_res = $signed(a) >>> shamt;
            ALU_OR:   alu_res = a | b;
            ALU_AND:  alu_res = a & b;
            default:  alu_res = '0;
        endcase
    end

    assign result_d = legal ? alu_res : '0;
    assign rf_we    = e_load && legal && (ZERO_REG == 0 || rd != 5'd0);

    always_comb begin
        d_valid_d = d_valid_q;
        if (d_load)      d_valid_d = 1'b1;
        else if (e_load) d_valid_d = 1'b0;
        e_valid_d = e_valid_q;
        if (e_load)                      e_valid_d = 1'b1;
        else if (e_valid_q && out_ready) e_valid_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_valid_q   <= 1'b0;
            d_instr_q   <= '0;
            e_valid_q   <= 1'b0;
            e_result_q  <= '0;
            e_rd_q      <= '0;
            e_illegal_q <= 1'b0;
        end else begin
            d_valid_q <= d_valid_d;
            e_valid_q <= e_valid_d;
            if (d_load) d_instr_q <= in_instr;
            if (e_load) begin
                e_result_q  <= result_d;
                e_rd_q      <= rd;
                e_illegal_q <= !legal;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        rf_q <= '0;
        else if (rf_we) rf_q[rd[AW-1:0]] <= alu_res;
    end

    assign out_valid   = e_valid_q;
    assign out_result  = e_result_q;
    assign out_rd      = e_rd_q;
    assign out_illegal = e_illegal_q;
    assign dbg_data    = (ZERO_REG != 0 && dbg_addr == '0) ? '0 : rf_q[dbg_addr];

endmodule

// File: tb/tb_decode_exec_pipe.sv
// Random and directed stimulus against a program-order reference model of the decode/execute pipe.
// The ISA has no immediates, so registers are seeded by writing the register file hierarchically while idle.
module tb_decode_exec_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        in_valid, in_ready, out_valid, out_ready, out_illegal;
    logic [31:0] in_instr, out_result, dbg_data;
    logic [4:0]  out_rd, dbg_addr;

    logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_illegal;
    logic [31:0] b_in_instr;
    logic [7:0]  b_out_result, b_dbg_data;
    logic [4:0]  b_out_rd;
    logic [2:0]  b_dbg_addr;

    decode_exec_pipe #(.N(32), .NREGS(32), .ZERO_REG(1)) dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result), .out_rd(out_rd),
        .out_illegal(out_illegal), .dbg_addr(dbg_addr), .dbg_data(dbg_data));

    decode_exec_pipe #(.N(8), .NREGS(8), .ZERO_REG(1)) dut1 (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready), .in_instr(b_in_instr),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_result(b_out_result), .out_rd(b_out_rd),
        .out_illegal(b_out_illegal), .dbg_addr(b_dbg_addr), .dbg_data(b_dbg_data));

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        ill;
        int          acc;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mrf[32];
    int          n_vec = 0, n_err = 0, edge_n = 0;
    logic [9:0]  ops[10];

    always @(posedge clk) edge_n++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] enc(input logic [6:0] f7, input logic [2:0] f3,
                                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
        return {f7, rs1, rs2, f3, rd, 7'b0110011};
    endfunction

    // Executes one instruction in program order on the model register file.
    task automatic model(input logic [31:0] ins, output exp_t e);
        logic [31:0] a, b, r;
        logic        ok;
        a  = mrf[ins[24:20]];
        b  = mrf[ins[19:15]];
        ok = (ins[6:0] == 7'h33);
        r  = 32'd0;
        case ({ins[31:25], ins[14:12]})
            {7'h00, 3'd0}: r = a + b;
            {7'h20, 3'd0}: r = a - b;
            {7'h00, 3'd1}: r = a << b[4:0];
            {7'h00, 3'd2}: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            {7'h00, 3'd3}: r = (a < b) ? 32'd1 : 32'd0;
            {7'h00, 3'd4}: r = a ^ b;
            {7'h00, 3'd5}: r = a >> b[4:0];
            {7'h20, 3'd5}: r = $signed(a) >>> b[4:0];
            {7'h00, 3'd6}: r = a | b;
            {7'h00, 3'd7}: r = a & b;
            default:       ok = 1'b0;
        endcase
        if (ok && ins[11:7] != 5'd0) mrf[ins[11:7]] = r;
        e.res = ok ? r : 32'd0;
        e.rd  = ins[11:7];
        e.ill = !ok;
        e.acc = 0;
    endtask

    task automatic compare();
        logic ev;
        ev = (q.size() > 0) && (q[0].acc < edge_n);
        chk("out_valid", out_valid, ev);
        chk("in_ready", in_ready, (q.size() < 2) || out_ready);
        if (ev) begin
            chk("out_result", out_result, q[0].res);
            chk("out_rd", out_rd, q[0].rd);
            chk("out_illegal", out_illegal, q[0].ill);
        end
    endtask

    // Called at a negedge; drives one cycle, updates the model, checks at the next negedge.
    task automatic step(input logic iv, input logic [31:0] ins, input logic ordy, output logic acc);
        exp_t e;
        in_valid = iv; in_instr = ins; out_ready = ordy;
        #1;
        acc = iv && in_ready;
        if (out_valid && out_ready && q.size() > 0) q.delete(0);
        if (acc) begin
            model(ins, e);
            e.acc = edge_n + 1;
            q.push_back(e);
        end
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic drain();
        logic a;
        for (int i = 0; i < 20 && q.size() > 0; i++) step(1'b0, 32'd0, 1'b1, a);
        if (q.size() != 0) chk("drain_timeout", q.size(), 0);
        for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 1'b1, a);
    endtask

    task automatic seed(input int idx, input logic [31:0] val);
        mrf[idx] = val;
        dut0.rf_q[idx] = val;
    endtask

    task automatic chk_rf();
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            chk("dbg_rf", dbg_data, mrf[i]);
        end
        @(negedge clk);
    endtask

    task automatic chk_reg(input logic [4:0] r, input logic [31:0] v);
        dbg_addr = r;
        #1;
        chk("dbg_reg", dbg_data, v);
    endtask

    function automatic logic [31:0] rand_instr();
        int k;
        k = $urandom_range(0, 11);
        if (k < 10)  return enc(ops[k][9:3], ops[k][2:0], 5'($urandom), 5'($urandom), 5'($urandom));
        if (k == 10) return enc(7'($urandom), 3'($urandom), 5'($urandom), 5'($urandom), 5'($urandom));
        return {$urandom} & 32'hFFFF_FF80 | 32'h13;
    endfunction

    task automatic b_issue(input string nm, input logic [31:0] ins, input logic [7:0] res,
                           input logic [4:0] rd, input logic ill);
        b_in_valid = 1'b1; b_in_instr = ins; b_out_ready = 1'b1;
        #1;
        chk({nm, "_in_ready"}, b_in_ready, 1'b1);
        @(posedge clk); @(negedge clk);
        b_in_valid = 1'b0;
        chk({nm, "_early"}, b_out_valid, 1'b0);
        @(posedge clk); @(negedge clk);
        chk({nm, "_valid"}, b_out_valid, 1'b1);
        chk({nm, "_result"}, b_out_result, res);
        chk({nm, "_rd"}, b_out_rd, rd);
        chk({nm, "_illegal"}, b_out_illegal, ill);
        @(posedge clk); @(negedge clk);
        chk({nm, "_retired"}, b_out_valid, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_rd", out_rd, 0);
        chk("rst_out_illegal", out_illegal, 1'b0);
        q.delete();
        for (int i = 0; i < 32; i++) mrf[i] = 32'd0;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        chk_rf();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic a;
        int   nacc, idx;
        ops = '{{7'h00, 3'd0}, {7'h20, 3'd0}, {7'h00, 3'd1}, {7'h00, 3'd2}, {7'h00, 3'd3},
                {7'h00, 3'd4}, {7'h00, 3'd5}, {7'h20, 3'd5}, {7'h00, 3'd6}, {7'h00, 3'd7}};
        in_valid = 0; in_instr = 0; out_ready = 1; dbg_addr = 0;
        b_in_valid = 0; b_in_instr = 0; b_out_ready = 1; b_dbg_addr = 0;
        rst = 1'b0;
        @(negedge clk);
        do_reset();

        // Dependent chain: 10-3=7, then 7+7=14 on the next cycle.
        seed(1, 32'd10); seed(2, 32'd3);
        step(1'b1, enc(7'h20, 3'd0, 5'd3, 5'd1, 5'd2), 1'b1, a);
        chk("model_sub", q[q.size()-1].res, 32'd7);
        step(1'b1, enc(7'h00, 3'd0, 5'd4, 5'd3, 5'd3), 1'b1, a);
        chk("model_add_dep", q[q.size()-1].res, 32'd14);
        drain();
        chk_reg(5'd4, 32'd14);
        @(negedge clk);

        // Backpressure: 4 dependent ADDs, only 2 fit while out_ready is low.
        seed(19, 32'd0);
        nacc = 0; idx = 0;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, enc(7'h00, 3'd0, 5'(20 + idx), 5'(19 + idx), 5'd1), 1'b0, a);
            if (a) begin nacc++; idx++; end
        end
        chk("bp_accepts", nacc, 2);
        for (int i = 0; i < 20 && idx < 4; i++) begin
            step(1'b1, enc(7'h00, 3'd0, 5'(20 + idx), 5'(19 + idx), 5'd1), 1'b1, a);
            if (a) idx++;
        end
        drain();
        chk_reg(5'd23, 32'd40);
        @(negedge clk);

        // Arithmetic boundaries.
        seed(5, 32'hFFFF_FFFF); seed(6, 32'd1); seed(7, 32'h8000_0000);
        seed(8, 32'd31); seed(9, 32'd33);
        step(1'b1, enc(7'h00, 3'd0, 5'd11, 5'd5, 5'd6), 1'b1, a);
        step(1'b1, enc(7'h20, 3'd5, 5'd12, 5'd7, 5'd8), 1'b1, a);
        step(1'b1, enc(7'h00, 3'd2, 5'd13, 5'd5, 5'd6), 1'b1, a);
        step(1'b1, enc(7'h00, 3'd3, 5'd14, 5'd5, 5'd6), 1'b1, a);
        step(1'b1, enc(7'h00, 3'd1, 5'd15, 5'd6, 5'd9), 1'b1, a);
        drain();
        chk_reg(5'd11, 32'd0);
        chk_reg(5'd12, 32'hFFFF_FFFF);
        chk_reg(5'd13, 32'd1);
        chk_reg(5'd14, 32'd0);
        chk_reg(5'd15, 32'd2);
        @(negedge clk);

        // Illegal opcode leaves the regfile alone; x0 ignores writes.
        seed(16, 32'h1234);
        step(1'b1, {7'h00, 5'd1, 5'd1, 3'd0, 5'd16, 7'b0010011}, 1'b1, a);
        chk("model_illegal", q[q.size()-1].ill, 1'b1);
        step(1'b1, enc(7'h00, 3'd0, 5'd0, 5'd1, 5'd1), 1'b1, a);
        drain();
        chk_reg(5'd16, 32'h1234);
        chk_reg(5'd0, 32'd0);
        @(negedge clk);

        // Randomized traffic with random backpressure.
        for (int i = 1; i < 32; i++) seed(i, $urandom);
        for (int i = 0; i < 600; i++)
            step($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 3) != 0, a);
        drain();
        chk_rf();

        // Reset with two instructions in flight.
        step(1'b1, enc(7'h00, 3'd0, 5'd3, 5'd1, 5'd2), 1'b0, a);
        step(1'b1, enc(7'h00, 3'd4, 5'd4, 5'd1, 5'd2), 1'b0, a);
        in_valid = 1'b0;
        #2;
        do_reset();
        for (int i = 0; i < 100; i++)
            step($urandom_range(0, 1) != 0, rand_instr(), $urandom_range(0, 1) != 0, a);
        drain();
        chk_rf();

        // N=8, NREGS=8 instance.
        dut1.rf_q[1] = 8'd200; dut1.rf_q[2] = 8'd100;
        dut1.rf_q[4] = 8'd9;   dut1.rf_q[6] = 8'd1;
        b_issue("n8_add", enc(7'h00, 3'd0, 5'd3, 5'd1, 5'd2), 8'd44, 5'd3, 1'b0);
        b_issue("n8_rd9", enc(7'h00, 3'd0, 5'd9, 5'd1, 5'd2), 8'd0, 5'd9, 1'b1);
        b_issue("n8_sll", enc(7'h00, 3'd1, 5'd5, 5'd6, 5'd4), 8'd2, 5'd5, 1'b0);
        b_dbg_addr = 3'd3;
        #1;
        chk("n8_dbg_x3", b_dbg_data, 8'd44);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
